compare_sequencer: RTL
======================

COMPARE_SEQUENCER -- requirements
Module: compare_sequencer

Interface
REQ-001 Parameter CNT_W, default 8: width of each event counter.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 din  input  4  operand nibble; first accepted nibble is A, second is B.
REQ-005 din_valid  input  1  din holds a valid nibble.
REQ-006 din_ready  output  1  block accepts din this cycle.
REQ-007 a0..a3, b0..b3  output  1 each  registered operand bits driven to the downstream magnitude comparator (a0/b0 = LSB).
REQ-008 aBIGGERb, aSMALLERb, aEQUALb  input  1 each  comparator result flags (combinational from a*/b*).
REQ-009 res_valid  output  1  res_code valid.
REQ-010 res_ready  input  1  consumer accepts result.
REQ-011 res_code  output  2  2'b01 A>B, 2'b10 A<B, 2'b00 A=B, 2'b11 flag error.
REQ-012 gt_cnt, lt_cnt, eq_cnt, err_cnt  output  CNT_W each  event counters.
REQ-013 err_sticky  output  1  set on any flag error, cleared only by rst.

Function
REQ-014 FSM states SHALL be IDLE, LOAD_B, COMPARE, HOLD; reset state IDLE.
REQ-015 IDLE: din_ready=1; on din_valid, din SHALL be registered to a3..a0 and the FSM SHALL go to LOAD_B; otherwise stay.
REQ-016 LOAD_B: din_ready=1; on din_valid, din SHALL be registered to b3..b0 and the FSM SHALL go to COMPARE; otherwise stay.
REQ-017 COMPARE: din_ready=0, lasts exactly one cycle; at its closing edge the flags SHALL be sampled into res_code, the matching counter incremented, and the FSM SHALL go to HOLD.
REQ-018 Flags SHALL be legal only when exactly one is high; zero or multiple high SHALL yield res_code=2'b11, err_cnt increment, err_sticky=1; gt/lt/eq counters unchanged.
REQ-019 HOLD: res_valid=1, din_ready=0; res_code and a*/b* SHALL stay stable until the handshake.
REQ-020 Handshake: on res_valid && res_ready the FSM SHALL return to IDLE next cycle with res_valid=0; res_ready outside HOLD SHALL be ignored.
REQ-021 Latency: B accepted at edge N -> res_valid high from edge N+2; minimum 4 cycles per compare with res_ready held high.
REQ-022 din_valid outside IDLE/LOAD_B SHALL be ignored (no capture, no state change).
REQ-023 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-024 a*/b* SHALL retain last captured values after HOLD until overwritten by next capture.
REQ-025 din_ready, res_valid SHALL be decoded from registered state only (no combinational path from din_valid or res_ready).

Reset
REQ-026 rst high SHALL immediately force: state IDLE, a*/b*=0, res_code=2'b00, res_valid=0, all counters 0, err_sticky=0; din_ready=1 once rst is low.
REQ-027 rst asserted in any state, including mid-HOLD, SHALL abort the transaction with no counter update; the first nibble after release is A.

Verification
REQ-028 din=9 then din=4, comparator model, res_ready=1 -> res_code=01, gt_cnt=1, res_valid for exactly 1 cycle.
REQ-029 Pairs (3,12) and (7,7) -> res_code 10 then 00; lt_cnt=1, eq_cnt=1, gt_cnt=0.
REQ-030 Force all three flags low during COMPARE -> res_code=11, err_cnt=1, err_sticky=1 held through later legal compares.
REQ-031 res_ready low 5 cycles in HOLD with din_valid toggling -> res_code and a*/b* stable, no capture, din_ready=0, result released on first res_ready.
REQ-032 CNT_W=2, five A>B compares -> gt_cnt=3 after 3rd, stays 3.
REQ-033 Assert rst in LOAD_B after A=15, then din=2, din=1 -> A=2, B=1, res_code=01, gt_cnt=1.

Source files
------------

// File: rtl/compare_sequencer.sv
// Captures two nibbles A and B, presents them to an external magnitude comparator and returns its verdict.
// A result is offered two edges after B is accepted and held until res_ready; din is refused while a result is pending.
module compare_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             a0,
  output logic             a1,
  output logic             a2,
  output logic             a3,
  output logic             b0,
  output logic             b1,
  output logic             b2,
  output logic             b3,
  input  logic             aBIGGERb,
  input  logic             aSMALLERb,
  input  logic             aEQUALb,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [1:0]       res_code,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_sticky
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_B  = 2'd1,
    COMPARE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state;
  state_t     nextState;
  logic [3:0] aReg;
  logic [3:0] bReg;
  logic       loadA;
  logic       loadB;
  logic       doCompare;
  logic [2:0] flags;
  logic [1:0] flagCode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (din_valid) nextState = LOAD_B;
      LOAD_B:  if (din_valid) nextState = COMPARE;
      COMPARE: nextState = HOLD;
      HOLD:    if (res_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Handshake outputs depend on state alone so neither ready nor valid sees a combinational input path.
  always_comb begin
    din_ready = 1'b0;
    res_valid = 1'b0;
    loadA     = 1'b0;
    loadB     = 1'b0;
    doCompare = 1'b0;
    case (state)
      IDLE: begin
        din_ready = 1'b1;
        loadA     = din_valid;
      end
      LOAD_B: begin
        din_ready = 1'b1;
        loadB     = din_valid;
      end
      COMPARE: doCompare = 1'b1;
      HOLD:    res_valid = 1'b1;
      default: ;
    endcase
  end

  // Anything other than exactly one flag high is a comparator fault.
  assign flags = {aBIGGERb, aSMALLERb, aEQUALb};

  always_comb begin
    case (flags)
      3'b100:  flagCode = 2'b01;
      3'b010:  flagCode = 2'b10;
      3'b001:  flagCode = 2'b00;
      default: flagCode = 2'b11;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aReg       <= 4'd0;
      bReg       <= 4'd0;
      res_code   <= 2'b00;
      gt_cnt     <= '0;
      lt_cnt     <= '0;
      eq_cnt     <= '0;
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (loadA) aReg <= din;
      if (loadB) bReg <= din;
      if (doCompare) begin
        res_code <= flagCode;
        case (flagCode)
          2'b01:   if (gt_cnt != CNT_MAX) gt_cnt <= gt_cnt + 1'b1;
          2'b10:   if (lt_cnt != CNT_MAX) lt_cnt <= lt_cnt + 1'b1;
          2'b00:   if (eq_cnt != CNT_MAX) eq_cnt <= eq_cnt + 1'b1;
          default: begin
            if (err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
            err_sticky <= 1'b1;
          end
        endcase
      end
    end
  end

  assign {a3, a2, a1, a0} = aReg;
  assign {b3, b2, b1, b0} = bReg;

endmodule
